// File: rtl/mem_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a windowed mem.
// One access per cycle, one response pulse per accept, a cycle later.
module mem_rr_arbiter #(
    parameter int WIDTH    = 80,
    parameter int DEPTH    = 32,
    parameter int OFFSET   = 32,
    parameter int AW       = 6,
    parameter int SYNCREAD = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [1:0]         req_write,
    input  logic [2*AW-1:0]    req_addr,
    input  logic [2*WIDTH-1:0] req_wdata,
    output logic [1:0]         resp_valid,
    output logic               resp_err,
    output logic [WIDTH-1:0]   resp_rdata,
    output logic               mem_ren,
    output logic [AW-1:0]      mem_raddr,
    input  logic [WIDTH-1:0]   mem_rdata,
    output logic               mem_wen,
    output logic [AW-1:0]      mem_waddr,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic [15:0]        err_count
);

    localparam logic [AW:0] LO = (AW+1)'(OFFSET);
    localparam logic [AW:0] HI = (AW+1)'(OFFSET + DEPTH);

    logic             last_b;
    logic [1:0]       gnt;
    logic             accept;
    logic             sel_b;
    logic [AW-1:0]    addr;
    logic             wr;
    logic [WIDTH-1:0] wdata;
    logic             in_win;
    logic [WIDTH-1:0] rdata_q;
    logic             pass_q;
    logic [15:0]      err_q;

    always_comb begin
        gnt = 2'b00;
        unique case (req_valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_b ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
        // ready is held low for as long as reset is asserted
        gnt = gnt & {2{rst}};
    end

    assign accept = |gnt;
    assign sel_b  = gnt[1];
    assign addr   = sel_b ? req_addr[2*AW-1:AW] : req_addr[AW-1:0];
    assign wr     = sel_b ? req_write[1] : req_write[0];
    assign wdata  = sel_b ? req_wdata[2*WIDTH-1:WIDTH]
                          : req_wdata[WIDTH-1:0];

    // one extra bit so OFFSET+DEPTH never wraps
    assign in_win = ({1'b0, addr} >= LO) && ({1'b0, addr} < HI);

    assign req_ready = gnt;
    assign mem_ren   = accept & ~wr & in_win;
    assign mem_wen   = accept & wr & in_win;
    assign mem_raddr = addr;
    assign mem_waddr = addr;
    assign mem_wdata = wdata;
    assign err_count = err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_b     <= 1'b1;
            resp_valid <= 2'b00;
            resp_err   <= 1'b0;
            rdata_q    <= '0;
            pass_q     <= 1'b0;
            err_q      <= 16'd0;
        end else begin
            resp_valid <= gnt;
            resp_err   <= accept & ~in_win;
            rdata_q    <= ((SYNCREAD == 0) && mem_ren) ? mem_rdata : '0;
            pass_q     <= (SYNCREAD != 0) && mem_ren;
            if (accept)
                last_b <= sel_b;
            if (accept && !in_win && err_q != 16'hFFFF)
                err_q <= err_q + 16'd1;
        end
    end

    // registered-read mem presents the data itself in the response cycle
    assign resp_rdata = pass_q ? mem_rdata : rdata_q;

endmodule
